llssine_mul_acc_pipe: RTL and testbench

// Parametrised pipelined multiplier with optional accumulate, next generation of the

---
 rtl/llssine_mul_acc_pipe.sv | 169 ++++++++++++++++
 tb/tb_llssine_mul_acc_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/llssine_mul_acc_pipe.sv
// Pipelined multiplier with configurable operand signedness and depth, feeding a saturating
// signed accumulator used for the LLS sum-of-products terms (sum x*y, sum x^2).
module llssine_mul_acc_pipe #(
  parameter int A_WIDTH   = 15,
  parameter int B_WIDTH   = 13,
  parameter bit A_SIGNED  = 1'b0,
  parameter bit B_SIGNED  = 1'b1,
  parameter int P_WIDTH   = 28,
  parameter int NUM_STAGE = 4,
  parameter int ACC_WIDTH = 40
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ce,
  input  logic                        in_valid,
  input  logic        [A_WIDTH-1:0]   a,
  input  logic        [B_WIDTH-1:0]   b,
  input  logic                        acc_en,
  input  logic                        acc_clr,
  output logic signed [P_WIDTH-1:0]   p,
  output logic                        p_valid,
  output logic signed [ACC_WIDTH-1:0] acc_out,
  output logic                        acc_valid,
  output logic                        acc_ovf
);

  // Product register plus NUM_STAGE-2 retiming registers; the last one drives p.
  localparam int NP   = NUM_STAGE - 1;
  localparam int LAST = NP - 1;

  logic        [A_WIDTH-1:0]   a_q, a_d;
  logic        [B_WIDTH-1:0]   b_q, b_d;
  logic                        s1_v_q, s1_v_d;
  logic                        s1_en_q, s1_en_d;
  logic                        s1_clr_q, s1_clr_d;

  logic signed [P_WIDTH-1:0]   prod_q [NP];
  logic signed [P_WIDTH-1:0]   prod_d [NP];
  logic        [NP-1:0]        pv_q, pv_d;
  logic        [NP-1:0]        pen_q, pen_d;
  logic        [NP-1:0]        pclr_q, pclr_d;

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        acc_valid_q, acc_valid_d;
  logic                        acc_ovf_q, acc_ovf_d;

  logic signed [A_WIDTH:0]     a_ext;
  logic signed [B_WIDTH:0]     b_ext;
  logic signed [P_WIDTH-1:0]   a_m, b_m, mul_p;

  logic signed [ACC_WIDTH:0]   p_ext, acc_ext, sum;
  logic                        sum_ovf;
  logic signed [ACC_WIDTH-1:0] sat_val;

  always_comb begin
    a_ext = A_SIGNED ? signed'({a_q[A_WIDTH-1], a_q}) : signed'({1'b0, a_q});
    b_ext = B_SIGNED ? signed'({b_q[B_WIDTH-1], b_q}) : signed'({1'b0, b_q});
    // Multiplying at P_WIDTH yields the full product modulo 2^P_WIDTH, which is exactly the
    // low-bit truncation when P_WIDTH is narrower and the sign extension when it is wider.
    a_m   = P_WIDTH'(a_ext);
    b_m   = P_WIDTH'(b_ext);
    mul_p = a_m * b_m;
  end

  always_comb begin
    p_ext   = (ACC_WIDTH+1)'(prod_q[LAST]);
    acc_ext = (ACC_WIDTH+1)'(acc_q);
    sum     = acc_ext + p_ext;
    sum_ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    sat_val = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
  end

  always_comb begin
    // NOTE: every _d starts as its _q so paths that skip an assignment hold state instead of
    // inferring a latch; this is also what makes ce=0 freeze the whole block.
    a_d         = a_q;
    b_d         = b_q;
    s1_v_d      = s1_v_q;
    s1_en_d     = s1_en_q;
    s1_clr_d    = s1_clr_q;
    prod_d      = prod_q;
    pv_d        = pv_q;
    pen_d       = pen_q;
    pclr_d      = pclr_q;
    acc_d       = acc_q;
    acc_valid_d = acc_valid_q;
    acc_ovf_d   = acc_ovf_q;

    if (ce) begin
      s1_v_d   = in_valid;
      s1_en_d  = acc_en;
      s1_clr_d = acc_clr;
      if (in_valid) begin
        a_d = a;
        b_d = b;
      end

      // Data registers only load on valid slots so p keeps its last product between pulses.
      pv_d[0]   = s1_v_q;
      pen_d[0]  = s1_en_q;
      pclr_d[0] = s1_clr_q;
      if (s1_v_q) prod_d[0] = mul_p;
      for (int k = 1; k < NP; k++) begin
        pv_d[k]   = pv_q[k-1];
        pen_d[k]  = pen_q[k-1];
        pclr_d[k] = pclr_q[k-1];
        if (pv_q[k-1]) prod_d[k] = prod_q[k-1];
      end

      acc_valid_d = 1'b0;
      if (pv_q[LAST] && pen_q[LAST]) begin
        acc_valid_d = 1'b1;
        if (pclr_q[LAST]) begin
          acc_d     = p_ext[ACC_WIDTH-1:0];
          acc_ovf_d = 1'b0;
        end else if (sum_ovf) begin
          acc_d     = sat_val;
          acc_ovf_d = 1'b1;
        end else begin
          acc_d     = sum[ACC_WIDTH-1:0];
        end
      end else if (pclr_q[LAST]) begin
        acc_d       = '0;
        acc_ovf_d   = 1'b0;
        acc_valid_d = 1'b1;
      end
    end
  end

  // NOTE: the pipeline registers are individual flops, not a RAM, so clearing them all on
  // reset is cheap and guarantees in-flight samples never surface afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q         <= '0;
      b_q         <= '0;
      s1_v_q      <= 1'b0;
      s1_en_q     <= 1'b0;
      s1_clr_q    <= 1'b0;
      for (int k = 0; k < NP; k++) prod_q[k] <= '0;
      pv_q        <= '0;
      pen_q       <= '0;
      pclr_q      <= '0;
      acc_q       <= '0;
      acc_valid_q <= 1'b0;
      acc_ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge value of its source.
      a_q         <= a_d;
      b_q         <= b_d;
      s1_v_q      <= s1_v_d;
      s1_en_q     <= s1_en_d;
      s1_clr_q    <= s1_clr_d;
      prod_q      <= prod_d;
      pv_q        <= pv_d;
      pen_q       <= pen_d;
      pclr_q      <= pclr_d;
      acc_q       <= acc_d;
      acc_valid_q <= acc_valid_d;
      acc_ovf_q   <= acc_ovf_d;
    end
  end

  assign p         = prod_q[LAST];
  assign p_valid   = pv_q[LAST];
  assign acc_out   = acc_q;
  assign acc_valid = acc_valid_q;
  assign acc_ovf   = acc_ovf_q;

endmodule

// File: tb/tb_llssine_mul_acc_pipe.sv
// Scoreboard bench: stimulus pushes model results into queues, a monitor pops them on output pulses.
module tb_llssine_mul_acc_pipe;

  localparam int A_W = 15, B_W = 13, P_W = 28, NS = 4, ACC_W = 40;
  localparam bit A_S = 1'b0, B_S = 1'b1;
  localparam longint ACC_MAX = (64'sd1 <<< (ACC_W-1)) - 1;
  localparam longint ACC_MIN = -(64'sd1 <<< (ACC_W-1));

  logic clk = 1'b0, reset = 1'b1, ce = 1'b0, in_valid = 1'b0, acc_en = 1'b0, acc_clr = 1'b0;
  logic [A_W-1:0] a = '0;
  logic [B_W-1:0] b = '0;
  logic signed [P_W-1:0]   p;
  logic                    p_valid, acc_valid, acc_ovf;
  logic signed [ACC_W-1:0] acc_out;

  // Small fully signed instance with P_WIDTH = ACC_WIDTH for the clamp and sign-extension cases.
  logic s_ce = 1'b1, s_in_valid = 1'b0, s_en = 1'b0, s_clr = 1'b0;
  logic [7:0] s_a = '0, s_b = '0;
  logic signed [19:0] s_p, s_acc;
  logic s_pv, s_av, s_ovf;

  always #5 clk = ~clk;

  llssine_mul_acc_pipe #(
    .A_WIDTH(A_W), .B_WIDTH(B_W), .A_SIGNED(A_S), .B_SIGNED(B_S),
    .P_WIDTH(P_W), .NUM_STAGE(NS), .ACC_WIDTH(ACC_W)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
    .acc_en(acc_en), .acc_clr(acc_clr), .p(p), .p_valid(p_valid),
    .acc_out(acc_out), .acc_valid(acc_valid), .acc_ovf(acc_ovf)
  );

  llssine_mul_acc_pipe #(
    .A_WIDTH(8), .B_WIDTH(8), .A_SIGNED(1'b1), .B_SIGNED(1'b1),
    .P_WIDTH(20), .NUM_STAGE(2), .ACC_WIDTH(20)
  ) dut_s (
    .clk(clk), .reset(reset), .ce(s_ce), .in_valid(s_in_valid), .a(s_a), .b(s_b),
    .acc_en(s_en), .acc_clr(s_clr), .p(s_p), .p_valid(s_pv),
    .acc_out(s_acc), .acc_valid(s_av), .acc_ovf(s_ovf)
  );

  typedef struct {
    longint val;
    bit     ovf;
    longint due;
  } exp_t;

  exp_t   p_exp[$];
  exp_t   acc_exp[$];
  longint acc_m = 0;
  bit     ovf_m = 1'b0;
  longint en_edges = 0;
  int     checks = 0, errors = 0;

  task automatic check(string name, logic signed [127:0] act, logic signed [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint op_val(longint raw, int w, bit sgn);
    if (sgn && raw[w-1]) return raw - (64'sd1 <<< w);
    return raw;
  endfunction

  function automatic longint wrap_s(longint v, int w);
    longint m;
    if (w >= 64) return v;
    m = v & ((64'sd1 <<< w) - 1);
    if (m[w-1]) m = m - (64'sd1 <<< w);
    return m;
  endfunction

  // Reference: sample enters at the next enabled edge E, p due at E+NS-1, accumulator at E+NS.
  task automatic model_issue(bit v, logic [A_W-1:0] ai, logic [B_W-1:0] bi, bit en, bit clr);
    longint e_edge, pv, s;
    e_edge = en_edges + 1;
    pv = 0;
    if (v) begin
      pv = wrap_s(op_val(longint'(ai), A_W, A_S) * op_val(longint'(bi), B_W, B_S), P_W);
      p_exp.push_back('{val: pv, ovf: 1'b0, due: e_edge + NS - 1});
    end
    if (v && en) begin
      if (clr) begin
        acc_m = pv;
        ovf_m = 1'b0;
      end else begin
        s = acc_m + pv;
        if (s > ACC_MAX) begin acc_m = ACC_MAX; ovf_m = 1'b1; end
        else if (s < ACC_MIN) begin acc_m = ACC_MIN; ovf_m = 1'b1; end
        else acc_m = s;
      end
      acc_exp.push_back('{val: acc_m, ovf: ovf_m, due: e_edge + NS});
    end else if (clr) begin
      acc_m = 0;
      ovf_m = 1'b0;
      acc_exp.push_back('{val: 0, ovf: 1'b0, due: e_edge + NS});
    end
  endtask

  task automatic cycle(bit ce_i, bit v, logic [A_W-1:0] ai, logic [B_W-1:0] bi, bit en, bit clr);
    ce = ce_i; in_valid = v; a = ai; b = bi; acc_en = en; acc_clr = clr;
    if (ce_i && !reset) model_issue(v, ai, bi, en, clr);
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(int n);
    reset = 1'b1; ce = 1'b0; in_valid = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
    acc_m = 0; ovf_m = 1'b0;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (p_exp.size() != 0 || acc_exp.size() != 0); i++) idle(1);
    check("drain_p_queue", p_exp.size(), 0);
    check("drain_acc_queue", acc_exp.size(), 0);
  endtask

  task automatic s_cycle(bit v, logic [7:0] sa, logic [7:0] sb, bit en, bit clr);
    s_in_valid = v; s_a = sa; s_b = sb; s_en = en; s_clr = clr;
    @(posedge clk); #1;
  endtask

  // Monitor: classify each edge, then compare outputs on the following falling edge.
  bit armed = 1'b0, edge_en = 1'b0, edge_rst = 1'b0;
  logic [70:0] prev_out;

  always @(posedge clk) begin
    armed    = 1'b1;
    edge_en  = ce && !reset;
    edge_rst = reset;
    if (reset) begin
      p_exp.delete();
      acc_exp.delete();
    end
    if (edge_en) en_edges++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (armed) begin
      if (edge_rst) begin
        check("reset_state", {p, p_valid, acc_out, acc_valid, acc_ovf}, 0);
      end else if (edge_en) begin
        if (p_valid) begin
          if (p_exp.size() == 0) check("p_valid_unexpected", p_valid, 0);
          else begin
            e = p_exp.pop_front();
            check("p_value", p, e.val);
            check("p_latency", en_edges, e.due);
          end
        end else if (p_exp.size() != 0 && p_exp[0].due <= en_edges) begin
          check("p_valid_missing", p_valid, 1);
          void'(p_exp.pop_front());
        end
        if (acc_valid) begin
          if (acc_exp.size() == 0) check("acc_valid_unexpected", acc_valid, 0);
          else begin
            e = acc_exp.pop_front();
            check("acc_value", acc_out, e.val);
            check("acc_ovf", acc_ovf, e.ovf);
            check("acc_latency", en_edges, e.due);
          end
        end else if (acc_exp.size() != 0 && acc_exp[0].due <= en_edges) begin
          check("acc_valid_missing", acc_valid, 1);
          void'(acc_exp.pop_front());
        end
      end else begin
        check("frozen_outputs", {p, p_valid, acc_out, acc_valid, acc_ovf}, prev_out);
      end
      prev_out = {p, p_valid, acc_out, acc_valid, acc_ovf};
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    do_reset(3);

    // Single product with spec latency.
    cycle(1'b1, 1'b1, 15'd32767, 13'h1000, 1'b0, 1'b0);
    idle(2);
    check("t1_p_valid_early", p_valid, 0);
    idle(1);
    check("t1_p_valid", p_valid, 1);
    check("t1_p", p, -134213632);
    drain();

    // Accumulated stream 1..8 times 2.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b1, A_W'(i), 13'd2, 1'b1, i == 1);
    drain();
    check("t2_acc_final", acc_out, 72);

    // ce dropped for three cycles mid-stream.
    for (int i = 0; i < 12; i++)
      cycle(!(i >= 5 && i < 8), 1'b1, A_W'($urandom), B_W'($urandom), 1'b1, i == 0);
    drain();

    // Randomised traffic including ce gaps, bubbles and clear-only slots.
    for (int i = 0; i < 300; i++) begin
      logic [A_W-1:0] ar;
      logic [B_W-1:0] br;
      ar = ($urandom_range(0, 3) == 0) ? '1 : A_W'($urandom);
      br = ($urandom_range(0, 3) == 0) ? 13'h1000 : B_W'($urandom);
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, ar, br,
            $urandom_range(0, 4) != 0, $urandom_range(0, 15) == 0);
    end
    drain();

    // Positive saturation of the 40-bit accumulator, then recovery on clear.
    cycle(1'b1, 1'b1, 15'd32767, 13'd4095, 1'b1, 1'b1);
    for (int i = 0; i < 4100; i++) cycle(1'b1, 1'b1, 15'd32767, 13'd4095, 1'b1, 1'b0);
    drain();
    check("sat_acc", acc_out, ACC_MAX);
    check("sat_ovf", acc_ovf, 1);
    cycle(1'b1, 1'b1, 15'd1, 13'd1, 1'b1, 1'b1);
    drain();
    check("sat_clr_ovf", acc_ovf, 0);
    check("sat_clr_acc", acc_out, 1);

    // Reset with three samples in flight and ce low.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, A_W'(i + 5), 13'd7, 1'b1, i == 0);
    do_reset(2);
    check("rst_outputs", {p, p_valid, acc_out, acc_valid, acc_ovf}, 0);
    idle(10);
    check("rst_no_pulses", {p_valid, acc_valid}, 0);

    // Signed 8x8 instance: products, clamping with P_WIDTH = ACC_WIDTH, clear-only slot.
    s_cycle(1'b1, 8'h80, 8'h80, 1'b0, 1'b0);
    s_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    check("s_p_neg_neg_valid", s_pv, 1);
    check("s_p_neg_neg", s_p, 16384);
    s_cycle(1'b1, 8'h80, 8'h7f, 1'b0, 1'b0);
    s_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    check("s_p_neg_pos", s_p, -16256);
    s_cycle(1'b1, 8'h80, 8'h80, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) s_cycle(1'b1, 8'h80, 8'h80, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) s_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    check("s_sat_pos", s_acc, 524287);
    check("s_sat_pos_ovf", s_ovf, 1);
    s_cycle(1'b1, 8'h80, 8'h7f, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) s_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    check("s_clr_acc", s_acc, -16256);
    check("s_clr_ovf", s_ovf, 0);
    for (int i = 0; i < 40; i++) s_cycle(1'b1, 8'h80, 8'h7f, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) s_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    check("s_sat_neg", s_acc, -524288);
    check("s_sat_neg_ovf", s_ovf, 1);
    s_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    s_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    check("s_clr_only_early", s_av, 0);
    s_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    check("s_clr_only_valid", s_av, 1);
    check("s_clr_only_acc", {s_acc, s_ovf}, 0);

    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
